// File: rtl/fetch.sv
// fetch: rv32i instruction fetch stage, directly upstream of decode.
//   Owns the PC, issues word-aligned reads over a req/gnt/rvalid handshake,
//   tags each outstanding request with its address and buffers returned
//   words in a small FIFO whose head drives decode. A redirect flushes the
//   buffer and drops every response still in flight for the old stream.
// Ports:
//   clk_i, rst_i                   clock, async active-high reset
//   fet_req_o, fet_addr_o          memory read request / word address
//   fet_gnt_i                      memory accepts the request this cycle
//   fet_rvalid_i, fet_rdata_i      in-order read response
//   fet_redirect_i/_pc_i           taken branch/jump and its target
//   fet_stall_i                    decode holds the current instruction
//   fet_valid_o, fet_inst_o, fet_pc_o  instruction and its address (0 when invalid)
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        fet_req_o,
  output logic [31:0] fet_addr_o,
  input  logic        fet_gnt_i,
  input  logic        fet_rvalid_i,
  input  logic [31:0] fet_rdata_i,
  input  logic        fet_redirect_i,
  input  logic [31:0] fet_redirect_pc_i,
  input  logic        fet_stall_i,
  output logic        fet_valid_o,
  output logic [31:0] fet_inst_o,
  output logic [31:0] fet_pc_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_tag_rd;
  logic [AW-1:0] r_tag_wr;
  logic [31:0]   r_inst_mem [FIFO_DEPTH];
  logic [31:0]   r_ipc_mem  [FIFO_DEPTH];
  logic [31:0]   r_tag_mem  [FIFO_DEPTH];

  logic [CW:0]   w_credit;
  logic [CW-1:0] w_out_next;
  logic          w_grant;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  // Credit covers both in-flight requests and buffered words, so every
  // response is guaranteed a FIFO slot.
  assign w_credit      = {1'b0, r_outstanding} + {1'b0, r_count};
  assign fet_req_o     = !rst_i && !fet_redirect_i && (w_credit < DEPTH_C);
  assign fet_addr_o    = r_pc;
  assign w_grant       = fet_req_o && fet_gnt_i;
  assign w_out_next    = r_outstanding + CW'(w_grant) - CW'(fet_rvalid_i);
  assign w_redirect_pc = fet_redirect_pc_i & 32'hFFFF_FFFC;

  // A response landing in the redirect cycle belongs to the old stream.
  assign w_drop = fet_rvalid_i && (fet_redirect_i || (r_discard != '0));
  assign w_push = fet_rvalid_i && !w_drop;

  assign fet_valid_o = (r_count != '0);
  assign w_pop       = fet_valid_o && !fet_stall_i;
  assign fet_inst_o  = fet_valid_o ? r_inst_mem[r_rd_ptr] : '0;
  assign fet_pc_o    = fet_valid_o ? r_ipc_mem[r_rd_ptr]  : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_tag_rd      <= '0;
      r_tag_wr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_grant) begin
        r_pc     <= r_pc + 32'd4;
        r_tag_wr <= r_tag_wr + AW'(1);
      end
      // The tag queue follows every response, dropped or not, so it stays
      // aligned with the memory's in-order returns across flushes.
      if (fet_rvalid_i) begin
        r_tag_rd <= r_tag_rd + AW'(1);
      end
      if (fet_redirect_i) begin
        r_pc      <= w_redirect_pc;
        r_discard <= w_out_next;
        r_count   <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
      end else begin
        if (fet_rvalid_i && (r_discard != '0)) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: entries are only visible behind r_count.
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= fet_rdata_i;
      r_ipc_mem[r_wr_ptr]  <= r_tag_mem[r_tag_rd];
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch.sv
`timescale 1ns/1ps
// Testbench for fetch: an in-order memory model with configurable latency
// and a scoreboard of expected {pc, inst} pairs, flushed on redirect.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned DEPTH  = 2;

  logic        clk;
  logic        rst_i;
  logic        fet_req_o;
  logic [31:0] fet_addr_o;
  logic        fet_gnt_i;
  logic        fet_rvalid_i;
  logic [31:0] fet_rdata_i;
  logic        fet_redirect_i;
  logic [31:0] fet_redirect_pc_i;
  logic        fet_stall_i;
  logic        fet_valid_o;
  logic [31:0] fet_inst_o;
  logic [31:0] fet_pc_o;

  fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .fet_req_o        (fet_req_o),
    .fet_addr_o       (fet_addr_o),
    .fet_gnt_i        (fet_gnt_i),
    .fet_rvalid_i     (fet_rvalid_i),
    .fet_rdata_i      (fet_rdata_i),
    .fet_redirect_i   (fet_redirect_i),
    .fet_redirect_pc_i(fet_redirect_pc_i),
    .fet_stall_i      (fet_stall_i),
    .fet_valid_o      (fet_valid_o),
    .fet_inst_o       (fet_inst_o),
    .fet_pc_o         (fet_pc_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_consumed = 0;
  bit          gnt_en = 1'b1;
  logic [31:0] tb_pc = RST_PC;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 8);
  endfunction

  // Memory model + scoreboard. Memory drives at the negedge; the scoreboard
  // samples at negedge+3, after the main sequence drives at negedge+1.
  always begin
    @(negedge clk);
    cyc++;
    fet_gnt_i = gnt_en;
    if (!rst_i && mem_q.size() > 0 && (mem_q[0].cyc + lat <= cyc)) begin
      fet_rvalid_i = 1'b1;
      fet_rdata_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      fet_rvalid_i = 1'b0;
      fet_rdata_i  = '0;
    end
    #3;
    if (rst_i) begin
      mem_q.delete();
      exp_q.delete();
      tb_pc = RST_PC;
    end else begin
      if (fet_valid_o && !fet_stall_i) begin
        checks++;
        n_consumed++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h inst=%h, expected no output", fet_pc_o, fet_inst_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (fet_pc_o !== e || fet_inst_o !== mem_word(e)) begin
            errors++;
            $display("FAIL sb_order: got pc=%h inst=%h, expected pc=%h inst=%h",
                     fet_pc_o, fet_inst_o, e, mem_word(e));
          end
        end
      end
      if (!fet_valid_o) begin
        checks++;
        if (fet_inst_o !== 32'h0 || fet_pc_o !== 32'h0) begin
          errors++;
          $display("FAIL invalid_zero: got inst=%h pc=%h, expected 0/0", fet_inst_o, fet_pc_o);
        end
      end
      if (fet_redirect_i) begin
        checks++;
        if (fet_req_o !== 1'b0) begin
          errors++;
          $display("FAIL req_in_redirect: got req=%b, expected 0", fet_req_o);
        end
        exp_q.delete();
        tb_pc = fet_redirect_pc_i & 32'hFFFF_FFFC;
      end else if (fet_req_o && fet_gnt_i) begin
        checks++;
        if (fet_addr_o !== tb_pc) begin
          errors++;
          $display("FAIL req_addr: got %h, expected %h", fet_addr_o, tb_pc);
        end
        mem_q.push_back('{addr: fet_addr_o, cyc: cyc});
        exp_q.push_back(tb_pc);
        tb_pc = tb_pc + 32'd4;
      end
      checks++;
      if (exp_q.size() > DEPTH) begin
        errors++;
        $display("FAIL credit: got %0d live requests, expected at most %0d", exp_q.size(), DEPTH);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (fet_valid_o) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = fet_valid_o;
  endtask

  task automatic test_reset();
    repeat (3) begin
      tick();
      checks++;
      if (fet_valid_o !== 1'b0 || fet_inst_o !== 32'h0 || fet_pc_o !== 32'h0 || fet_req_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h req=%b, expected all 0",
                 fet_valid_o, fet_inst_o, fet_pc_o, fet_req_o);
      end
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (fet_req_o !== 1'b1 || fet_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h, expected 1/00000100", fet_req_o, fet_addr_o);
    end
  endtask

  task automatic test_streaming();
    bit ok;
    int c0;
    wait_valid(10, ok);
    checks++;
    if (!ok || fet_pc_o !== 32'h100 || fet_inst_o !== 32'h0051_0093) begin
      errors++;
      $display("FAIL stream_first: got valid=%b pc=%h inst=%h, expected 1/00000100/00510093",
               fet_valid_o, fet_pc_o, fet_inst_o);
    end
    c0 = n_consumed;
    repeat (30) tick();
    checks++;
    if (n_consumed - c0 < 15) begin
      errors++;
      $display("FAIL stream_rate: got %0d instructions in 30 cycles, expected at least 15", n_consumed - c0);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    wait_valid(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_start: got valid=0, expected 1");
    end
    fet_stall_i = 1'b1;
    hold_pc     = fet_pc_o;
    hold_inst   = fet_inst_o;
    repeat (4) begin
      tick();
      checks++;
      if (fet_valid_o !== 1'b1 || fet_pc_o !== hold_pc || fet_inst_o !== hold_inst) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b pc=%h inst=%h, expected 1/%h/%h",
                 fet_valid_o, fet_pc_o, fet_inst_o, hold_pc, hold_inst);
      end
    end
    checks++;
    if (fet_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_req: got req=%b, expected 0", fet_req_o);
    end
    fet_stall_i = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_redirect_outstanding();
    bit found;
    bit req_seen;
    int n_rv;
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_q.size() == 2 && !fet_rvalid_i) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir2_setup: got no cycle with 2 outstanding, expected one within 20");
    end
    fet_redirect_i    = 1'b1;
    fet_redirect_pc_i = 32'h0000_2002;
    tick();
    fet_redirect_i = 1'b0;
    #1;
    checks++;
    if (fet_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redir2_flush: got valid=%b, expected 0", fet_valid_o);
    end
    n_rv     = 0;
    req_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fet_valid_o) break;
      if (fet_req_o && !req_seen) begin
        req_seen = 1'b1;
        checks++;
        if (fet_addr_o !== 32'h0000_2000) begin
          errors++;
          $display("FAIL redir2_addr: got %h, expected 00002000", fet_addr_o);
        end
      end
      if (fet_rvalid_i) n_rv++;
      tick();
    end
    checks++;
    if (!fet_valid_o || fet_pc_o !== 32'h0000_2000 || n_rv != 3 || !req_seen) begin
      errors++;
      $display("FAIL redir2_first: got valid=%b pc=%h rvalids=%0d req_seen=%b, expected 1/00002000/3/1",
               fet_valid_o, fet_pc_o, n_rv, req_seen);
    end
    lat = 1;
    repeat (8) tick();
  endtask

  task automatic test_redirect_timing();
    bit found;
    gnt_en = 1'b0;
    repeat (2) tick();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_q.size() == 0 && !fet_rvalid_i) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirt_idle: got outstanding=%0d, expected 0", mem_q.size());
    end
    fet_redirect_i    = 1'b1;
    fet_redirect_pc_i = 32'h0000_3001;
    gnt_en            = 1'b1;
    tick();
    fet_redirect_i = 1'b0;
    #1;
    checks++;
    if (fet_req_o !== 1'b1 || fet_addr_o !== 32'h0000_3000 || fet_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redirt_n1: got req=%b addr=%h valid=%b, expected 1/00003000/0",
               fet_req_o, fet_addr_o, fet_valid_o);
    end
    tick();
    checks++;
    if (fet_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL redirt_n2: got valid=%b, expected 0", fet_valid_o);
    end
    tick();
    checks++;
    if (fet_valid_o !== 1'b1 || fet_pc_o !== 32'h0000_3000 || fet_inst_o !== mem_word(32'h0000_3000)) begin
      errors++;
      $display("FAIL redirt_n3: got valid=%b pc=%h inst=%h, expected 1/00003000/%h",
               fet_valid_o, fet_pc_o, fet_inst_o, mem_word(32'h0000_3000));
    end
    repeat (6) tick();
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    bit ok;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fet_rvalid_i) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redirv_setup: got no rvalid, expected one within 10 cycles");
    end
    fet_redirect_i    = 1'b1;
    fet_redirect_pc_i = 32'h0000_4000;
    tick();
    fet_redirect_i = 1'b0;
    wait_valid(15, ok);
    checks++;
    if (!ok || fet_pc_o !== 32'h0000_4000) begin
      errors++;
      $display("FAIL redirv_first: got valid=%b pc=%h, expected 1/00004000", fet_valid_o, fet_pc_o);
    end
    repeat (6) tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    tick();
    fet_redirect_i    = 1'b1;
    fet_redirect_pc_i = 32'h0000_5000;
    tick();
    fet_redirect_pc_i = 32'h0000_6006;
    tick();
    fet_redirect_i = 1'b0;
    wait_valid(15, ok);
    checks++;
    if (!ok || fet_pc_o !== 32'h0000_6004) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b pc=%h, expected 1/00006004", fet_valid_o, fet_pc_o);
    end
    repeat (6) tick();
  endtask

  task automatic test_wrap_async_reset();
    bit found;
    fet_redirect_i    = 1'b1;
    fet_redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    fet_redirect_i = 1'b0;
    #1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fet_req_o && fet_addr_o == 32'h0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_addr: got addr=%h, expected 00000000 after FFFFFFFC", fet_addr_o);
    end
    fet_stall_i = 1'b1;
    repeat (6) tick();
    checks++;
    if (fet_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: got valid=%b, expected 1", fet_valid_o);
    end
    // Mid-cycle: the next posedge is 4 ns away.
    rst_i = 1'b1;
    #1;
    checks++;
    if (fet_valid_o !== 1'b0 || fet_inst_o !== 32'h0 || fet_pc_o !== 32'h0 || fet_req_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b inst=%h pc=%h req=%b, expected all 0",
               fet_valid_o, fet_inst_o, fet_pc_o, fet_req_o);
    end
    fet_stall_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (fet_req_o !== 1'b1 || fet_addr_o !== RST_PC) begin
      errors++;
      $display("FAIL post_reset_req: got req=%b addr=%h, expected 1/%h", fet_req_o, fet_addr_o, RST_PC);
    end
    repeat (10) tick();
  endtask

  initial begin
    rst_i             = 1'b1;
    fet_gnt_i         = 1'b0;
    fet_rvalid_i      = 1'b0;
    fet_rdata_i       = '0;
    fet_redirect_i    = 1'b0;
    fet_redirect_pc_i = '0;
    fet_stall_i       = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_outstanding();
    test_redirect_timing();
    test_redirect_rvalid();
    test_back_to_back();
    test_wrap_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
